// File: rtl/uart_ss_multi_edge_filter.sv
`default_nettype none
// ============================================================================
// Module      : uart_ss_multi_edge_filter
// Description : Multi-channel synchroniser, glitch filter and edge detector
//               for the UART subsystem (RX line, CTS, break/wake inputs).
//               Each channel has a SYNC_STAGES-flop synchroniser and a
//               debounce filter that needs FILT_LEN stable cycles. It then
//               produces registered rise/fall pulses, a mode-qualified event
//               pulse and a sticky event flag with clear.
// Ports       : i_clk     - clock
//               i_rst_n   - asynchronous active-low reset
//               i_en      - filter/detector enable
//               i_signal  - [N_CH]   asynchronous raw inputs
//               i_mode    - [2*N_CH] per-channel mode (00 off, 01 rise,
//                                    10 fall, 11 both)
//               i_clr     - [N_CH]   sticky flag clear (level)
//               o_level   - [N_CH]   filtered, synchronised level
//               o_rise    - [N_CH]   1-cycle pulse, o_level went 0->1
//               o_fall    - [N_CH]   1-cycle pulse, o_level went 1->0
//               o_pulse   - [N_CH]   1-cycle pulse, edge qualified by mode
//               o_flag    - [N_CH]   sticky event flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ss_multi_edge_filter #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter bit RST_VAL     = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [N_CH-1:0]   i_signal,
    input  logic [2*N_CH-1:0] i_mode,
    input  logic [N_CH-1:0]   i_clr,
    output logic [N_CH-1:0]   o_level,
    output logic [N_CH-1:0]   o_rise,
    output logic [N_CH-1:0]   o_fall,
    output logic [N_CH-1:0]   o_pulse,
    output logic [N_CH-1:0]   o_flag
);

    localparam int            CW        = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] c_CNT_MAX = CW'(FILT_LEN - 1);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CW-1:0]          r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_pulse;
        logic                   r_flag;

        logic w_s;
        logic w_diff;
        logic w_accept;
        logic w_rise_nxt;
        logic w_fall_nxt;
        logic w_pulse_nxt;

        assign w_s    = r_sync[SYNC_STAGES-1];
        assign w_diff = (w_s != r_level);
        // The new value is accepted on the edge that would complete the
        // FILT_LEN-th consecutive differing sample.
        assign w_accept    = i_en && w_diff && (r_cnt == c_CNT_MAX);
        assign w_rise_nxt  = w_accept &  w_s;
        assign w_fall_nxt  = w_accept & ~w_s;
        assign w_pulse_nxt = (w_rise_nxt & i_mode[2*c])
                           | (w_fall_nxt & i_mode[2*c+1]);

        // Synchroniser runs regardless of i_en so the filter sees a
        // current value the moment it is re-enabled.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sync <= {SYNC_STAGES{RST_VAL}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal[c]};
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt   <= '0;
                r_level <= RST_VAL;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_pulse <= 1'b0;
                r_flag  <= 1'b0;
            end else begin
                // A single matching sample, or disable, discards the run.
                if (!i_en || !w_diff || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_accept) begin
                    r_level <= w_s;
                end
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
                r_pulse <= w_pulse_nxt;
                // A new event in the clearing cycle wins over the clear.
                r_flag  <= (r_flag & ~i_clr[c]) | w_pulse_nxt;
            end
        end

        assign o_level[c] = r_level;
        assign o_rise[c]  = r_rise;
        assign o_fall[c]  = r_fall;
        assign o_pulse[c] = r_pulse;
        assign o_flag[c]  = r_flag;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_ss_multi_edge_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ss_multi_edge_filter
// Description : Self-checking bench for uart_ss_multi_edge_filter. Each
//               stimulus step pushes the edge events it should cause, at the
//               cycle they should appear, onto a scoreboard. A monitor pops
//               and compares them whenever the DUT emits rise/fall/pulse.
//               Inputs change just after the falling edge. A change driven
//               at cycle d is therefore first sampled on edge d+1 and
//               appears at the outputs after edge d+6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ss_multi_edge_filter;

    localparam int N_CH = 4;
    localparam int LAT  = 6;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_en;
    logic [N_CH-1:0]   i_signal;
    logic [2*N_CH-1:0] i_mode;
    logic [N_CH-1:0]   i_clr;
    logic [N_CH-1:0]   o_level;
    logic [N_CH-1:0]   o_rise;
    logic [N_CH-1:0]   o_fall;
    logic [N_CH-1:0]   o_pulse;
    logic [N_CH-1:0]   o_flag;

    typedef struct {
        int           cyc;
        logic [3:0]   rise;
        logic [3:0]   fall;
        logic [3:0]   pulse;
    } ev_t;

    ev_t sb[$];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    uart_ss_multi_edge_filter #(
        .N_CH        (N_CH),
        .SYNC_STAGES (2),
        .FILT_LEN    (4),
        .RST_VAL     (1'b1)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (i_en),
        .i_signal (i_signal),
        .i_mode   (i_mode),
        .i_clr    (i_clr),
        .o_level  (o_level),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_pulse  (o_pulse),
        .o_flag   (o_flag)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Scoreboard monitor: compares every emitted event against the queue.
    always @(negedge i_clk) begin
        ev_t ev;
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event: cycle %0d got nothing, required rise=%b fall=%b pulse=%b at cycle %0d",
                     cyc, sb[0].rise, sb[0].fall, sb[0].pulse, sb[0].cyc);
            void'(sb.pop_front());
        end
        if ((o_rise | o_fall | o_pulse) != 4'b0000) begin
            n_cmp++;
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                n_bad++;
                $display("FAIL unexpected_event: cycle %0d got rise=%b fall=%b pulse=%b, none required",
                         cyc, o_rise, o_fall, o_pulse);
            end else begin
                ev = sb.pop_front();
                if ({o_rise, o_fall, o_pulse} !== {ev.rise, ev.fall, ev.pulse}) begin
                    n_bad++;
                    $display("FAIL event_value: cycle %0d got rise=%b fall=%b pulse=%b, required rise=%b fall=%b pulse=%b",
                             cyc, o_rise, o_fall, o_pulse, ev.rise, ev.fall, ev.pulse);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1; i_en = 1'b1; i_signal = 4'h0; i_mode = '0; i_clr = '0;
        #1 i_rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({o_level, o_rise, o_fall, o_pulse, o_flag} !== {4'hF, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_async: got level=%h r=%h f=%h p=%h flag=%h, required level=F others 0",
                     o_level, o_rise, o_fall, o_pulse, o_flag);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            i_signal = 4'($urandom);
            i_clr    = 4'($urandom);
            n_cmp++;
            if ({o_level, o_rise, o_fall, o_pulse, o_flag} !== {4'hF, 16'h0}) begin
                n_bad++;
                $display("FAIL reset_hold: got level=%h r=%h f=%h p=%h flag=%h, required level=F others 0",
                         o_level, o_rise, o_fall, o_pulse, o_flag);
            end
        end
        @(negedge i_clk);
        i_signal = 4'hF; i_clr = '0; i_rst_n = 1'b1;
        wait_cyc(20);
        n_cmp++;
        if (o_level !== 4'hF || o_flag !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_release: got level=%h flag=%h, required level=F flag=0", o_level, o_flag);
        end
    endtask

    task automatic test_fall_ch0();
        int d;
        @(negedge i_clk);
        i_mode = 8'b00_00_00_10;
        i_signal[0] = 1'b0;
        d = cyc;
        sb.push_back('{d + LAT, 4'b0000, 4'b0001, 4'b0001});
        wait_cyc(LAT);
        n_cmp++;
        if (o_level[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL fall_level: got %b, required 0", o_level[0]);
        end
        wait_cyc(1);
        n_cmp++;
        if (o_flag !== 4'b0001 || o_rise !== 4'b0000) begin
            n_bad++;
            $display("FAIL fall_flag: got flag=%b rise=%b, required flag=0001 rise=0000", o_flag, o_rise);
        end
    endtask

    task automatic test_glitch_ch1();
        int d;
        @(negedge i_clk);
        i_signal[1] = 1'b0;
        wait_cyc(3);
        i_signal[1] = 1'b1;
        wait_cyc(8);
        n_cmp++;
        if (o_level[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_reject: got level[1]=%b, required 1", o_level[1]);
        end
        @(negedge i_clk);
        i_signal[1] = 1'b0;
        d = cyc;
        sb.push_back('{d + LAT, 4'b0000, 4'b0010, 4'b0000});
        wait_cyc(4);
        i_signal[1] = 1'b1;
        sb.push_back('{d + 4 + LAT, 4'b0010, 4'b0000, 4'b0000});
        wait_cyc(2);
        n_cmp++;
        if (o_level[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_accept: got level[1]=%b, required 0", o_level[1]);
        end
        wait_cyc(6);
        n_cmp++;
        if (o_level[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_return: got level[1]=%b, required 1", o_level[1]);
        end
    endtask

    task automatic test_both_edges();
        int d;
        @(negedge i_clk);
        i_mode = 8'b00_11_00_10;
        i_signal[3:2] = 2'b00;
        d = cyc;
        sb.push_back('{d + LAT, 4'b0000, 4'b1100, 4'b0100});
        wait_cyc(10);
        i_signal[3:2] = 2'b11;
        sb.push_back('{d + 10 + LAT, 4'b1100, 4'b0000, 4'b0100});
        wait_cyc(8);
        n_cmp++;
        if (o_flag !== 4'b0101 || o_level !== 4'b1110) begin
            n_bad++;
            $display("FAIL both_edges: got flag=%b level=%b, required flag=0101 level=1110", o_flag, o_level);
        end
    endtask

    task automatic test_clear_ch0();
        int d;
        @(negedge i_clk);
        i_signal[0] = 1'b1;
        d = cyc;
        sb.push_back('{d + LAT, 4'b0001, 4'b0000, 4'b0000});
        wait_cyc(8);
        i_signal[0] = 1'b0;
        d = cyc;
        sb.push_back('{d + LAT, 4'b0000, 4'b0001, 4'b0001});
        wait_cyc(LAT - 1);
        i_clr = 4'b0001;
        wait_cyc(1);
        i_clr = 4'b0000;
        n_cmp++;
        if (o_flag[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_set_wins: got flag[0]=%b, required 1", o_flag[0]);
        end
        wait_cyc(2);
        i_clr = 4'b0001;
        wait_cyc(1);
        i_clr = 4'b0000;
        n_cmp++;
        if (o_flag !== 4'b0100) begin
            n_bad++;
            $display("FAIL clear_alone: got flag=%b, required 0100", o_flag);
        end
    endtask

    task automatic test_enable_and_reset();
        int d;
        @(negedge i_clk);
        i_signal[0] = 1'b1;
        d = cyc;
        sb.push_back('{d + LAT, 4'b0001, 4'b0000, 4'b0000});
        wait_cyc(8);
        i_signal[0] = 1'b0;
        d = cyc;
        wait_cyc(4);
        i_en = 1'b0;
        wait_cyc(5);
        n_cmp++;
        if (o_level[0] !== 1'b1 || o_flag !== 4'b0100) begin
            n_bad++;
            $display("FAIL enable_freeze: got level[0]=%b flag=%b, required level[0]=1 flag=0100", o_level[0], o_flag);
        end
        i_en = 1'b1;
        sb.push_back('{d + 9 + 4, 4'b0000, 4'b0001, 4'b0001});
        wait_cyc(4);
        n_cmp++;
        if (o_level[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_restart: got level[0]=%b, required 0", o_level[0]);
        end
        wait_cyc(2);
        i_signal[0] = 1'b1;
        wait_cyc(4);
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_level, o_rise, o_fall, o_pulse, o_flag} !== {4'hF, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_midcount: got level=%h r=%h f=%h p=%h flag=%h, required level=F others 0",
                     o_level, o_rise, o_fall, o_pulse, o_flag);
        end
        @(negedge i_clk);
        i_signal = 4'hF;
        i_rst_n  = 1'b1;
        wait_cyc(20);
        n_cmp++;
        if (o_level !== 4'hF || sb.size() != 0) begin
            n_bad++;
            $display("FAIL reset_midcount_release: got level=%h pending=%0d, required level=F pending=0",
                     o_level, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fall_ch0();
        test_glitch_ch1();
        test_both_edges();
        test_clear_ch0();
        test_enable_and_reset();
        wait_cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
